uart_tx: RTL and testbench

UART transmitter, the transmit-side counterpart of the peripheral UART receiver. It serialises one 8-bit byte per frame onto tx_o: start bit, 8 data bits LSB first, optional even parity bit, then 1 or 2 stop bits.
- Takes bytes from the peripheral controller over a valid/ready handshake.
- Uses the same baud-rate selection and divider table as the receiver.
- clk_i is 10 MHz.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx.sv | 126 ++++++++++++
 tb/tb_uart_tx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divider table, transmitter states and frame width.
// The divider table and lookup are shared with the receiver.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [16:0] BAUD_9600   = 17'd9600;
    localparam logic [16:0] BAUD_19200  = 17'd19200;
    localparam logic [16:0] BAUD_38400  = 17'd38400;
    localparam logic [16:0] BAUD_57600  = 17'd57600;
    localparam logic [16:0] BAUD_115200 = 17'd115200;

    localparam logic [15:0] DIV_9600   = 16'd1041;
    localparam logic [15:0] DIV_19200  = 16'd520;
    localparam logic [15:0] DIV_38400  = 16'd259;
    localparam logic [15:0] DIV_57600  = 16'd173;
    localparam logic [15:0] DIV_115200 = 16'd86;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP_BIT  = 3'd4
    } tx_state_e;

    // Unknown rates fall back to the slowest supported divider.
    function automatic logic [15:0] baud_div(input logic [16:0] baud);
        case (baud)
            BAUD_9600:   return DIV_9600;
            BAUD_19200:  return DIV_19200;
            BAUD_38400:  return DIV_38400;
            BAUD_57600:  return DIV_57600;
            BAUD_115200: return DIV_115200;
            default:     return DIV_9600;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the peripheral controller (master) and the UART transmitter (slave).
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;

    modport master (output tx_data_i, output tx_valid_i, input  tx_ready_o);
    modport slave  (input  tx_data_i, input  tx_valid_i, output tx_ready_o);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..div and flags the last clock of each bit period.
module uart_baud_gen (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] div,
    output logic        bit_done
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clear || !enable) begin
            cnt_q <= '0;
        end else if (cnt_q == div) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // Kept independent of clear: the caller derives clear from bit_done.
    assign bit_done = enable && (cnt_q == div);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8E1/8N2/8E2 frames from a valid/ready byte stream, LSB first.
module uart_tx
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        tx_o,
    output logic        busy_o,
    input  logic [16:0] baudrate_i,
    input  logic        parity_en_i,
    input  logic [1:0]  stopbit_i,
    uart_tx_if.slave    tx_if
);

    tx_state_e         state_q, state_d;
    logic              tx_q, tx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [15:0]       div_q, div_d;
    logic              par_en_q, par_en_d;
    logic              two_stop_q, two_stop_d;

    logic bit_done;
    logic final_stop;
    logic tx_ready;
    logic accept;

    uart_baud_gen u_baud_gen (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .enable   (state_q != IDLE),
        .clear    (state_d != state_q),
        .div      (div_q),
        .bit_done (bit_done)
    );

    // bit_cnt is reused in STOP_BIT to tell the first of two stop bits from the second.
    assign final_stop = (state_q == STOP_BIT) && (!two_stop_q || bit_cnt_q == 3'd1);
    assign tx_ready   = (state_q == IDLE) || (final_stop && bit_done);
    assign accept     = tx_if.tx_valid_i && tx_ready;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        tx_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) state_d = START_BIT;
            end
            START_BIT: begin
                parity_d = 1'b0;
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    parity_d  = parity_q ^ shift_q[0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = par_en_q ? PARITY : STOP_BIT;
                end
            end
            PARITY: begin
                if (bit_done) state_d = STOP_BIT;
            end
            STOP_BIT: begin
                if (bit_done) begin
                    if (final_stop) state_d = accept ? START_BIT : IDLE;
                    else            bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame configuration is frozen at the handshake.
        if (accept) begin
            shift_d    = tx_if.tx_data_i;
            div_d      = baud_div(baudrate_i);
            par_en_d   = parity_en_i;
            two_stop_d = (stopbit_i == 2'd2);
            bit_cnt_d  = 3'd0;
            parity_d   = 1'b0;
        end

        // The line level is registered from the next state so it changes with the state.
        case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA:      tx_d = shift_d[0];
            PARITY:    tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
        end
    end

    assign tx_o              = tx_q;
    assign busy_o            = (state_q != IDLE);
    assign tx_if.tx_ready_o  = tx_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line, busy and ready waveforms are built from frame rules.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tx;
    logic        busy;
    logic [16:0] baud;
    logic        par_en;
    logic [1:0]  stopbit;

    int checks_total  = 0;
    int checks_passed = 0;

    bit exp_tx[$];
    bit exp_busy[$];
    bit exp_ready[$];

    uart_tx_if bus ();

    uart_tx dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .tx_o        (tx),
        .busy_o      (busy),
        .baudrate_i  (baud),
        .parity_en_i (par_en),
        .stopbit_i   (stopbit),
        .tx_if       (bus)
    );

    always #5 clk = ~clk;

    // Clocks per bit at a 10 MHz system clock.
    function automatic int model_period(input logic [16:0] b);
        case (b)
            17'd9600:   return 1042;
            17'd19200:  return 521;
            17'd38400:  return 260;
            17'd57600:  return 174;
            17'd115200: return 87;
            default:    return 1042;
        endcase
    endfunction

    // Sends nframes bytes (b0 then b1) with tx_valid_i held high and compares every cycle
    // after the first handshake against a per-bit level model.
    task automatic run_frames(input string name, input logic [7:0] b0, input logic [7:0] b1,
                              input int nframes, input logic [16:0] b, input bit p,
                              input logic [1:0] s, input int change_at);
        int per       = model_period(b);
        int tx_err    = 0;
        int busy_err  = 0;
        int ready_err = 0;
        int hs        = 0;
        int busy_cnt  = 0;
        int waited    = 0;
        int frame_len = 0;
        bit hs_now;
        logic [7:0] cur;
        bit levels[$];

        exp_tx.delete();
        exp_busy.delete();
        exp_ready.delete();
        for (int f = 0; f < nframes; f++) begin
            cur = (f == 0) ? b0 : b1;
            levels.delete();
            levels.push_back(1'b0);
            for (int j = 0; j < 8; j++) levels.push_back(cur[j]);
            if (p) levels.push_back(^cur);
            levels.push_back(1'b1);
            if (s == 2'd2) levels.push_back(1'b1);
            for (int l = 0; l < levels.size(); l++) begin
                for (int c = 0; c < per; c++) begin
                    exp_tx.push_back(levels[l]);
                    exp_busy.push_back(1'b1);
                    exp_ready.push_back((l == levels.size() - 1) && (c == per - 1));
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            exp_tx.push_back(1'b1);
            exp_busy.push_back(1'b0);
            exp_ready.push_back(1'b1);
        end
        frame_len = per * (10 + (p ? 1 : 0) + ((s == 2'd2) ? 1 : 0)) * nframes;

        @(negedge clk);
        baud = b;
        par_en = p;
        stopbit = s;
        bus.tx_data_i = b0;
        bus.tx_valid_i = 1'b1;
        while (bus.tx_ready_o !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.tx_ready_o === 1'b1) hs = 1;
        @(posedge clk);
        #1;
        if (nframes > 1 && hs == 1) bus.tx_data_i = b1;
        else bus.tx_valid_i = 1'b0;

        for (int i = 0; i < exp_tx.size(); i++) begin
            if (i > 0) begin
                @(negedge clk);
                hs_now = (bus.tx_valid_i === 1'b1) && (bus.tx_ready_o === 1'b1);
                if (hs_now) hs++;
                @(posedge clk);
                #1;
                if (hs_now) begin
                    if (hs < nframes) bus.tx_data_i = b1;
                    else bus.tx_valid_i = 1'b0;
                end
            end
            if (i == change_at) begin
                baud = 17'd9600;
                par_en = 1'b1;
                bus.tx_data_i = ~b0;
            end
            if (tx !== exp_tx[i]) tx_err++;
            if (busy !== exp_busy[i]) busy_err++;
            if (bus.tx_ready_o !== exp_ready[i]) ready_err++;
            if (busy === 1'b1) busy_cnt++;
        end

        checks_total++;
        if (tx_err !== 0) $display("[TB] FAIL %s tx_o: %0d cycles wrong, required 0", name, tx_err);
        else checks_passed++;
        checks_total++;
        if (busy_err !== 0) $display("[TB] FAIL %s busy_o: %0d cycles wrong, required 0", name, busy_err);
        else checks_passed++;
        checks_total++;
        if (ready_err !== 0) $display("[TB] FAIL %s tx_ready_o: %0d cycles wrong, required 0", name, ready_err);
        else checks_passed++;
        checks_total++;
        if (hs !== nframes) $display("[TB] FAIL %s handshakes: actual %0d required %0d", name, hs, nframes);
        else checks_passed++;
        checks_total++;
        if (busy_cnt !== frame_len) $display("[TB] FAIL %s busy length: actual %0d required %0d", name, busy_cnt, frame_len);
        else checks_passed++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.tx_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks_total++;
        if (tx !== 1'b1) $display("[TB] FAIL reset tx_o: actual %b required 1", tx);
        else checks_passed++;
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL reset busy_o: actual %b required 0", busy);
        else checks_passed++;
        checks_total++;
        if (bus.tx_ready_o !== 1'b1) $display("[TB] FAIL reset tx_ready_o: actual %b required 1", bus.tx_ready_o);
        else checks_passed++;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic_frame();
        run_frames("basic", 8'hA5, 8'h00, 1, 17'd115200, 1'b0, 2'd1, -1);
    endtask

    task automatic test_parity_two_stop();
        run_frames("parity_2stop", 8'h07, 8'h00, 1, 17'd115200, 1'b1, 2'd2, -1);
    endtask

    task automatic test_back_to_back();
        run_frames("back_to_back", 8'h55, 8'h0F, 2, 17'd115200, 1'b0, 2'd1, -1);
    endtask

    task automatic test_unlisted_baud();
        run_frames("unlisted_baud", 8'h00, 8'h00, 1, 17'd12345, 1'b0, 2'd1, -1);
    endtask

    task automatic test_config_stability();
        logic [7:0] d = 8'($urandom);
        run_frames("config_stable", d, 8'h00, 1, 17'd115200, 1'b0, 2'd1, 300);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'($urandom);
        @(negedge clk);
        baud = 17'd115200;
        par_en = 1'b0;
        stopbit = 2'd1;
        bus.tx_data_i = d;
        bus.tx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid_i = 1'b0;
        repeat (4 * 87 + 40) @(posedge clk);
        #1;
        checks_total++;
        if (tx !== d[3]) $display("[TB] FAIL mid_data bit3: actual %b required %b", tx, d[3]);
        else checks_passed++;
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        checks_total++;
        if (tx !== 1'b1) $display("[TB] FAIL mid_reset tx_o: actual %b required 1", tx);
        else checks_passed++;
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL mid_reset busy_o: actual %b required 0", busy);
        else checks_passed++;
        checks_total++;
        if (bus.tx_ready_o !== 1'b1) $display("[TB] FAIL mid_reset tx_ready_o: actual %b required 1", bus.tx_ready_o);
        else checks_passed++;
        @(negedge clk);
        rstn = 1'b1;
        run_frames("after_reset", 8'h3C, 8'h00, 1, 17'd115200, 1'b0, 2'd1, -1);
    endtask

    task automatic test_random_frames();
        logic [16:0] b;
        for (int n = 0; n < 3; n++) begin
            b = ($urandom_range(0, 1) == 0) ? 17'd115200 : 17'd57600;
            run_frames($sformatf("random%0d", n), 8'($urandom), 8'($urandom),
                       1 + int'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), -1);
        end
    endtask

    initial begin
        rstn = 1'b0;
        baud = 17'd115200;
        par_en = 1'b0;
        stopbit = 2'd1;
        bus.tx_data_i = 8'h00;
        bus.tx_valid_i = 1'b0;
        test_reset();
        test_basic_frame();
        test_parity_two_stop();
        test_back_to_back();
        test_unlisted_baud();
        test_config_stability();
        test_reset_mid_frame();
        test_random_frames();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
